// File: rtl/tm1637_pkg.sv
// Shared constants, state encoding and command record for the TM1637 frame sequencer.
// Pure definitions: no logic, no latency, no flow control of its own.
package tm1637_pkg;

   localparam int CMD_BYTE_W = 8;
   localparam int BRIGHT_W   = 3;
   localparam int IDX_W      = 4;
   localparam int MAX_DIGITS = 6;

   localparam logic [CMD_BYTE_W-1:0] CMD_DATA_AUTOINC = 8'h40;
   localparam logic [CMD_BYTE_W-1:0] CMD_ADDR_BASE    = 8'hC0;
   localparam logic [CMD_BYTE_W-1:0] CMD_DISP_CTRL    = 8'h80;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_DONE,
      ST_FINISH
   } seq_state_t;

   typedef struct packed {
      logic                  start;
      logic                  stop;
      logic [CMD_BYTE_W-1:0] dat;
   } cmd_t;

   function automatic logic [CMD_BYTE_W-1:0] disp_ctrl_byte(
      input logic                display_on,
      input logic [BRIGHT_W-1:0] brightness
   );
      return CMD_DISP_CTRL | {4'b0000, display_on, brightness};
   endfunction

endpackage

// File: rtl/tm1637_frame_builder.sv
// Maps a frame byte index plus the frame snapshot to the byte and its start/stop framing.
// Purely combinational; zero latency; no backpressure of its own.
module tm1637_frame_builder
   import tm1637_pkg::*;
#(
   parameter int NUM_DIGITS = 4
) (
   input  logic [IDX_W-1:0]        index,
   input  logic [8*NUM_DIGITS-1:0] digits,
   input  logic [BRIGHT_W-1:0]     brightness,
   input  logic                    display_on,
   output cmd_t                    cmd
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS + 2);

   always_comb begin
      cmd = '0;
      if (index == IDX_W'(0)) begin
         cmd = '{start: 1'b1, stop: 1'b1, dat: CMD_DATA_AUTOINC};
      end else if (index == IDX_W'(1)) begin
         // address command opens the transaction that carries the digit bytes
         cmd = '{start: 1'b1, stop: 1'b0, dat: CMD_ADDR_BASE};
      end else if (index == LAST_IDX) begin
         cmd = '{start: 1'b1, stop: 1'b1, dat: disp_ctrl_byte(display_on, brightness)};
      end else begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if (index == IDX_W'(k + 2)) begin
               cmd.dat   = digits[8*k +: 8];
               cmd.start = 1'b0;
               cmd.stop  = (k == NUM_DIGITS - 1);
            end
         end
      end
   end

endmodule

// File: rtl/tm1637_frame_sequencer.sv
// Sequences one TM1637 display frame (data cmd, address, digits, display ctrl) into a byte engine.
// One byte in flight; waits on cmd_ready per byte and on eng_done before offering the next.
module tm1637_frame_sequencer
   import tm1637_pkg::*;
#(
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk_50M,
   input  logic                    rst_n,
   input  logic                    update_req,
   input  logic [8*NUM_DIGITS-1:0] digits,
   input  logic [BRIGHT_W-1:0]     brightness,
   input  logic                    display_on,
   output logic                    cmd_valid,
   output logic [CMD_BYTE_W-1:0]   cmd_byte,
   output logic                    cmd_start,
   output logic                    cmd_stop,
   input  logic                    cmd_ready,
   input  logic                    eng_done,
   input  logic                    eng_nak,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS + 2);

   seq_state_t                state, state_nxt;
   logic [IDX_W-1:0]          idx, idx_nxt;
   logic                      pending, pending_nxt;
   logic                      err_q, err_nxt;
   logic                      take_snap;
   logic [8*NUM_DIGITS-1:0]   snap_digits;
   logic [BRIGHT_W-1:0]       snap_bright;
   logic                      snap_on;
   cmd_t                      cur_cmd;

   tm1637_frame_builder #(
      .NUM_DIGITS (NUM_DIGITS)
   ) u_builder (
      .index      (idx),
      .digits     (snap_digits),
      .brightness (snap_bright),
      .display_on (snap_on),
      .cmd        (cur_cmd)
   );

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         idx     <= '0;
         pending <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         idx     <= idx_nxt;
         pending <= pending_nxt;
         err_q   <= err_nxt;
      end
   end

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         snap_digits <= '0;
         snap_bright <= '0;
         snap_on     <= 1'b0;
      end else if (take_snap) begin
         snap_digits <= digits;
         snap_bright <= brightness;
         snap_on     <= display_on;
      end
   end

   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      pending_nxt = pending;
      err_nxt     = err_q;
      take_snap   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            // eng_done here is stale and deliberately not looked at
            if (update_req || pending) begin
               state_nxt   = ST_ISSUE;
               idx_nxt     = '0;
               err_nxt     = 1'b0;
               pending_nxt = 1'b0;
               take_snap   = 1'b1;
            end
         end
         ST_ISSUE: begin
            if (update_req) pending_nxt = 1'b1;
            if (cmd_ready) state_nxt = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (update_req) pending_nxt = 1'b1;
            if (eng_done) begin
               if (eng_nak) begin
                  err_nxt   = 1'b1;
                  state_nxt = ST_FINISH;
               end else if (idx == LAST_IDX) begin
                  state_nxt = ST_FINISH;
               end else begin
                  idx_nxt   = idx + IDX_W'(1);
                  state_nxt = ST_ISSUE;
               end
            end
         end
         ST_FINISH: begin
            // a request landing in this cycle is folded straight into the next frame
            if (pending || update_req) begin
               state_nxt   = ST_ISSUE;
               idx_nxt     = '0;
               err_nxt     = 1'b0;
               pending_nxt = 1'b0;
               take_snap   = 1'b1;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_valid = (state == ST_ISSUE);
      cmd_byte  = cmd_valid ? cur_cmd.dat   : '0;
      cmd_start = cmd_valid ? cur_cmd.start : 1'b0;
      cmd_stop  = cmd_valid ? cur_cmd.stop  : 1'b0;
      busy      = (state == ST_ISSUE) || (state == ST_WAIT_DONE);
      done      = (state == ST_FINISH);
      err       = err_q;
   end

endmodule

// File: tb/tb_tm1637_frame_sequencer.sv
// Directed + randomized bench for tm1637_frame_sequencer against a frame-list reference model.
module tb_tm1637_frame_sequencer;

   localparam int N = 4;

   logic          clk_50M = 1'b0;
   logic          rst_n;
   logic          update_req;
   logic [8*N-1:0] digits;
   logic [2:0]    brightness;
   logic          display_on;
   logic          cmd_valid;
   logic [7:0]    cmd_byte;
   logic          cmd_start;
   logic          cmd_stop;
   logic          cmd_ready;
   logic          eng_done;
   logic          eng_nak;
   logic          busy;
   logic          done;
   logic          err;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] exp_byte  [0:N+2];
   logic       exp_start [0:N+2];
   logic       exp_stop  [0:N+2];
   int         exp_len;

   tm1637_frame_sequencer #(.NUM_DIGITS(N)) dut (
      .clk_50M    (clk_50M),
      .rst_n      (rst_n),
      .update_req (update_req),
      .digits     (digits),
      .brightness (brightness),
      .display_on (display_on),
      .cmd_valid  (cmd_valid),
      .cmd_byte   (cmd_byte),
      .cmd_start  (cmd_start),
      .cmd_stop   (cmd_stop),
      .cmd_ready  (cmd_ready),
      .eng_done   (eng_done),
      .eng_nak    (eng_nak),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #10 clk_50M = ~clk_50M;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick;
      @(posedge clk_50M);
      #1;
   endtask

   // Frame as a list of (byte, start, stop) built from the display protocol rules.
   task automatic model_frame(input logic [8*N-1:0] d, input logic [2:0] b, input logic on);
      exp_len = N + 3;
      exp_byte[0] = 8'h40; exp_start[0] = 1'b1; exp_stop[0] = 1'b1;
      exp_byte[1] = 8'hC0; exp_start[1] = 1'b1; exp_stop[1] = 1'b0;
      for (int k = 0; k < N; k++) begin
         exp_byte[k+2]  = d[8*k +: 8];
         exp_start[k+2] = 1'b0;
         exp_stop[k+2]  = (k == N - 1);
      end
      exp_byte[N+2]  = 8'(128 + (on ? 8 : 0) + int'(b));
      exp_start[N+2] = 1'b1;
      exp_stop[N+2]  = 1'b1;
   endtask

   task automatic start_frame;
      update_req = 1'b1;
      tick;
      update_req = 1'b0;
      chk("start_valid", cmd_valid, 1);
      chk("start_busy", busy, 1);
      chk("start_err_clear", err, 0);
   endtask

   task automatic serve(input int nak_at, input int stall_byte, input int stall_len,
                        input int fixed_delay, input int req_a, input int req_b,
                        input int chg_at, input logic [8*N-1:0] chg_val, input int abort_at);
      for (int i = 0; i < exp_len; i++) begin
         int stall;
         int dly;
         stall = (i == stall_byte) ? stall_len : int'($urandom_range(0, 2));
         cmd_ready = 1'b0;
         for (int s = 0; s < stall; s++) begin
            eng_done = 1'($urandom_range(0, 1));
            chk("stall_valid", cmd_valid, 1);
            chk("stall_byte", cmd_byte, exp_byte[i]);
            tick;
         end
         eng_done  = 1'b0;
         cmd_ready = 1'b1;
         chk("offer_valid", cmd_valid, 1);
         chk("offer_byte", cmd_byte, exp_byte[i]);
         chk("offer_start", cmd_start, exp_start[i]);
         chk("offer_stop", cmd_stop, exp_stop[i]);
         tick;
         cmd_ready = 1'b0;
         chk("accepted_once", cmd_valid, 0);
         chk("wait_busy", busy, 1);
         if (i == abort_at) return;
         dly = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(2, 5));
         for (int w = 1; w < dly; w++) begin
            update_req = (w == 1) && (i == req_a || i == req_b);
            if (w == 1 && i == chg_at) digits = chg_val;
            cmd_ready = 1'($urandom_range(0, 1));
            tick;
            chk("wait_quiet", cmd_valid, 0);
         end
         update_req = 1'b0;
         cmd_ready  = 1'b0;
         eng_done   = 1'b1;
         eng_nak    = (i == nak_at);
         tick;
         eng_done = 1'b0;
         eng_nak  = 1'b0;
         if (i == nak_at || i == exp_len - 1) begin
            chk("done_pulse", done, 1);
            chk("finish_busy", busy, 0);
            chk("finish_valid", cmd_valid, 0);
            chk("finish_err", err, (i == nak_at));
            return;
         end
         chk("done_low", done, 0);
      end
   endtask

   initial begin
      bit          exp_err;
      int          nak;
      logic [31:0] rnd;

      rst_n = 1'b0; update_req = 1'b0; digits = '0; brightness = '0; display_on = 1'b0;
      cmd_ready = 1'b0; eng_done = 1'b0; eng_nak = 1'b0;
      tick; tick; tick;
      chk("rst_valid", cmd_valid, 0);
      chk("rst_byte", cmd_byte, 0);
      chk("rst_start", cmd_start, 0);
      chk("rst_stop", cmd_stop, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      rst_n = 1'b1;
      tick;

      cmd_ready = 1'b1;
      tick;
      cmd_ready = 1'b0;
      chk("idle_ready_ignored", cmd_valid, 0);
      chk("idle_busy", busy, 0);

      // Reference frame, engine ready, 3-cycle done, no NAK
      digits = 32'h3F06_5B4F; brightness = 3'd7; display_on = 1'b1;
      model_frame(digits, brightness, display_on);
      start_frame;
      serve(-1, -1, 0, 3, -1, -1, -1, '0, -1);
      tick;
      chk("post_done_low", done, 0);
      chk("post_idle", cmd_valid, 0);

      // NAK on the first digit byte aborts; err sticky until next frame
      model_frame(digits, brightness, display_on);
      start_frame;
      serve(2, -1, 0, 3, -1, -1, -1, '0, -1);
      tick;
      chk("nak_err_sticky", err, 1);
      chk("nak_no_more", cmd_valid, 0);
      tick;
      chk("nak_still_idle", busy, 0);
      model_frame(digits, brightness, display_on);
      start_frame;
      serve(-1, -1, 0, 3, -1, -1, -1, '0, -1);
      tick;

      // Long backpressure on the address byte
      model_frame(digits, brightness, display_on);
      start_frame;
      serve(-1, 1, 10, 3, -1, -1, -1, '0, -1);
      tick;

      // Two merged requests plus a digit change mid-frame: one extra frame of zeros
      model_frame(digits, brightness, display_on);
      start_frame;
      serve(-1, -1, 0, 0, 1, 4, 3, 32'h0000_0000, -1);
      tick;
      chk("pend_valid", cmd_valid, 1);
      chk("pend_busy", busy, 1);
      chk("pend_byte", cmd_byte, 8'h40);
      model_frame(32'h0000_0000, brightness, display_on);
      serve(-1, -1, 0, 0, -1, -1, -1, '0, -1);
      tick;
      chk("pend_single", cmd_valid, 0);
      tick; tick;
      chk("pend_idle", busy, 0);

      // Request in idle coinciding with a stale eng_done
      rnd = $urandom;
      digits = rnd;
      model_frame(digits, brightness, display_on);
      eng_done = 1'b1;
      update_req = 1'b1;
      tick;
      eng_done = 1'b0;
      update_req = 1'b0;
      chk("stale_valid", cmd_valid, 1);
      chk("stale_byte", cmd_byte, 8'h40);
      serve(-1, -1, 0, 0, -1, -1, -1, '0, -1);
      tick;

      // Randomized frames, optional NAK, mid-frame input churn without requests
      for (int f = 0; f < 8; f++) begin
         rnd = $urandom;
         digits = rnd;
         brightness = 3'($urandom_range(0, 7));
         display_on = 1'($urandom_range(0, 1));
         nak = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N + 2)) : -1;
         exp_err = (nak >= 0);
         model_frame(digits, brightness, display_on);
         start_frame;
         rnd = $urandom;
         serve(nak, -1, 0, 0, -1, -1, int'($urandom_range(0, N + 1)), rnd, -1);
         brightness = 3'($urandom_range(0, 7));
         for (int g = 0; g < int'($urandom_range(1, 3)); g++) tick;
         chk("rand_err", err, exp_err);
         chk("rand_idle", busy, 0);
      end

      // Async reset during WAIT_DONE of byte 3 with a request pending
      digits = 32'h3F06_5B4F; brightness = 3'd7; display_on = 1'b1;
      model_frame(digits, brightness, display_on);
      start_frame;
      serve(-1, -1, 0, 3, 1, -1, -1, '0, 3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_valid", cmd_valid, 0);
      chk("mrst_byte", cmd_byte, 0);
      chk("mrst_start", cmd_start, 0);
      chk("mrst_stop", cmd_stop, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      chk("mrst_err", err, 0);
      tick; tick;
      rst_n = 1'b1;
      tick;
      eng_done = 1'b1;
      tick;
      eng_done = 1'b0;
      for (int c = 0; c < 6; c++) begin
         chk("post_rst_valid", cmd_valid, 0);
         chk("post_rst_busy", busy, 0);
         tick;
      end

      model_frame(digits, brightness, display_on);
      start_frame;
      serve(-1, -1, 0, 3, -1, -1, -1, '0, -1);
      tick;
      chk("final_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
